mem_bist: RTL

Built-in self-test initiator for the single-port `mem` block. It drives `mem`'s address, write-data and write-enable pins, so it sits on the opposite side of the port that `mem` exposes. On a `start` pulse it runs a four-phase write/read-compare sequence over every address, stops at the first mismatch, and reports pass/fail with the failing address and data. It replaces hand-written write/read-back stimulus and is also instantiated in-system for power-on memory checks.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/delay_line.sv | 45 ++++
 rtl/mem_bist.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for mem initiators.
//   mem_state_e  - sequencer state encoding (IDLE, WR0, RD0, WR1, RD1, FIN)
//   mem_pattern  - test pattern P(a) = a XOR seed, optionally inverted. It is computed at
//                  32 bits; the caller casts the result down to its word width.
package mem_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWr0,
      StRd0,
      StWr1,
      StRd1,
      StFin
   } mem_state_e;

   function automatic logic [31:0] mem_pattern(logic [31:0] addr, logic [31:0] seed, logic inv);
      logic [31:0] p;
      p = addr ^ seed;
      return inv ? ~p : p;
   endfunction

endpackage

// File: rtl/delay_line.sv
// delay_line: fixed-depth shift pipeline with a per-stage valid bit.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset, clears the valid bits
//   clr       synchronous clear of the valid bits (flushes in-flight entries)
//   in_valid  entry valid at the input
//   in_data   entry payload at the input
//   out_valid entry valid after DEPTH cycles
//   out_data  entry payload after DEPTH cycles
module delay_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= in_valid;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
         end
      end
      // Payload needs no reset; it is qualified by valid.
      data_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
         data_q[i] <= data_q[i-1];
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mem_bist.sv
// mem_bist: built-in self-test initiator for the single-port mem block.
// Runs WR0 (write P(a)), RD0 (compare P(a)), WR1 (write ~P(a)), RD1 (compare ~P(a)) over
// all 2^ADDR addresses, stopping at the first mismatch.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a test (accepted only in IDLE)
//   mem_addr      address to mem (registered)
//   mem_data_in   write data to mem (registered)
//   mem_wr        write enable to mem (registered)
//   mem_data_out  read data from mem, valid RD_LAT cycles after the address
//   busy          test in progress
//   done          one-cycle end-of-test pulse
//   pass          result, held until the next accepted start
//   fail_addr     first failing address (0 on pass)
//   fail_data     data observed at fail_addr (0 on pass)
module mem_bist
   import mem_pkg::*;
#(
   parameter int unsigned ADDR   = 4,
   parameter int unsigned WORD   = 4,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned SEED   = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [ADDR-1:0] mem_addr,
   output logic [WORD-1:0] mem_data_in,
   output logic            mem_wr,
   input  logic [WORD-1:0] mem_data_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ADDR-1:0] fail_addr,
   output logic [WORD-1:0] fail_data
);

   localparam int unsigned DlWidth = ADDR + WORD;
   localparam logic [ADDR-1:0] LastAddr = '1;

   mem_state_e      state_q, state_d;
   logic [ADDR-1:0] cnt_q, cnt_d;
   logic            issue_q, issue_d;
   logic            wr_q, wr_d;
   logic [WORD-1:0] wdata_q, wdata_d;
   logic            pass_q, pass_d;
   logic [ADDR-1:0] fail_addr_q, fail_addr_d;
   logic [WORD-1:0] fail_data_q, fail_data_d;

   logic               dl_clr, dl_in_valid, dl_out_valid;
   logic [DlWidth-1:0] dl_in_data, dl_out_data;
   logic [ADDR-1:0]    exp_addr;
   logic [WORD-1:0]    exp_data;
   logic               in_rd;

   assign {exp_addr, exp_data} = dl_out_data;
   assign in_rd = (state_q == StRd0) || (state_q == StRd1);

   delay_line #(
      .DEPTH (RD_LAT),
      .WIDTH (DlWidth)
   ) u_delay_line (
      .clk       (clk),
      .rst       (rst),
      .clr       (dl_clr),
      .in_valid  (dl_in_valid),
      .in_data   (dl_in_data),
      .out_valid (dl_out_valid),
      .out_data  (dl_out_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      issue_d     = issue_q;
      pass_d      = pass_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      dl_in_valid = 1'b0;
      dl_in_data  = {cnt_q, WORD'(mem_pattern(32'(cnt_q), 32'(SEED), state_q == StRd1))};

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (start) begin
               state_d     = StWr0;
               pass_d      = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
            end
         end
         StWr0, StWr1: begin
            if (cnt_q == LastAddr) begin
               cnt_d   = '0;
               issue_d = 1'b1;
               state_d = (state_q == StWr0) ? StRd0 : StRd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRd0, StRd1: begin
            if (issue_q) begin
               dl_in_valid = 1'b1;
               if (cnt_q == LastAddr) begin
                  issue_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            if (dl_out_valid) begin
               if (mem_data_out != exp_data) begin
                  state_d     = StFin;
                  pass_d      = 1'b0;
                  fail_addr_d = exp_addr;
                  fail_data_d = mem_data_out;
                  issue_d     = 1'b0;
                  cnt_d       = '0;
               end else if (exp_addr == LastAddr) begin
                  // The last compare of the phase closes it; no separate drain counter.
                  cnt_d = '0;
                  if (state_q == StRd0) begin
                     state_d = StWr1;
                  end else begin
                     state_d = StFin;
                     pass_d  = 1'b1;
                  end
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Pins are loaded from next-state so they line up with cnt_q in the following cycle.
      wr_d    = (state_d == StWr0) || (state_d == StWr1);
      wdata_d = wr_d ? WORD'(mem_pattern(32'(cnt_d), 32'(SEED), state_d == StWr1)) : '0;
      dl_clr  = in_rd && (state_d != state_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         issue_q     <= 1'b0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         pass_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         issue_q     <= issue_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         pass_q      <= pass_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
      end
   end

   assign mem_addr    = cnt_q;
   assign mem_wr      = wr_q;
   assign mem_data_in = wdata_q;
   assign busy        = (state_q != StIdle) && (state_q != StFin);
   assign done        = (state_q == StFin);
   assign pass        = pass_q;
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;

endmodule
